// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared constants, state encoding and helpers for the memory controller
package mem_ctrl_pkg;
  localparam logic [31:0] MC_IO_BASE = 32'h0003_0000;
  localparam logic [2:0] F3_LB = 3'b000, F3_LH = 3'b001, F3_LW = 3'b010, F3_LBU = 3'b100, F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB = 3'b000, F3_SH = 3'b001, F3_SW = 3'b010;
  localparam logic [1:0] MC_IDLE = 2'd0, MC_FETCH = 2'd1, MC_LOAD = 2'd2, MC_STORE = 2'd3;
  function automatic logic [2:0] nbytes(input logic [1:0] sz);
    return sz == 2'b00 ? 3'd1 : sz == 2'b01 ? 3'd2 : 3'd4;
  endfunction
  function automatic logic [31:0] ext_load(input logic [2:0] op, input logic [31:0] d);
    return op[1] ? d : op[0] ? {{16{d[15] & ~op[2]}}, d[15:0]} : {{24{d[7] & ~op[2]}}, d[7:0]};
  endfunction
endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises one word-level LSB/IF request at a time over the 8-bit little-endian memory bus
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [31:0] IO_BASE = MC_IO_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rob_clear,
  input  logic        lsb_req,
  input  logic        lsb_is_store,
  input  logic [2:0]  lsb_op,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_wdata,
  output logic        lsb_welcome,
  output logic        lsb_done,
  output logic [31:0] lsb_rdata,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_instr,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);
  logic [1:0] state;
  logic [2:0] op, cnt, n;
  logic [31:0] addr, wdata, buf_q, buf_n, a_q, cur_a;
  logic [7:0] d_q;
  logic [4:0] sh_r, sh_w;
  logic sup, ld_done, f_done, rd_act, st, io_hold, accept_ok;
  // byte sequencing: current address/data byte, IO throttling and assembly of the incoming byte
  always_comb begin
    n = nbytes(op[1:0]);
    st = state == MC_STORE;
    rd_act = (state == MC_LOAD || state == MC_FETCH) && cnt < n;
    cur_a = addr + {29'd0, cnt};
    io_hold = st && cur_a >= IO_BASE && io_buffer_full;
    sh_r = {cnt[1:0] - 2'd1, 3'b000};
    sh_w = {cnt[1:0], 3'b000};
    buf_n = (buf_q & ~(32'hFF << sh_r)) | ({24'd0, mem_din} << sh_r);
    accept_ok = state == MC_IDLE && !rob_clear && !ld_done && !f_done;
    lsb_welcome = rdy && accept_ok;
    mem_a = (rd_act || st) ? cur_a : a_q;
    mem_dout = st ? 8'(wdata >> sh_w) : d_q;
    mem_wr = rdy && st && !io_hold;
    lsb_done = rdy && ld_done;
    if_done = rdy && f_done;
  end
  // request acceptance, per-byte progress, completion and flush handling
  always_ff @(posedge clk)
    if (rst) begin
      state <= MC_IDLE;
      op <= 3'd0;
      cnt <= 3'd0;
      addr <= 32'd0;
      wdata <= 32'd0;
      buf_q <= 32'd0;
      a_q <= 32'd0;
      d_q <= 8'd0;
      sup <= 1'b0;
      ld_done <= 1'b0;
      f_done <= 1'b0;
      lsb_rdata <= 32'd0;
      if_instr <= 32'd0;
    end else if (rdy) begin
      ld_done <= 1'b0;
      f_done <= 1'b0;
      if (rd_act || st) a_q <= cur_a;
      if (st) d_q <= mem_dout;
      if (state == MC_IDLE) begin
        cnt <= 3'd0;
        sup <= 1'b0;
        buf_q <= 32'd0;
        if (accept_ok && lsb_req) begin
          state <= lsb_is_store ? MC_STORE : MC_LOAD;
          addr <= lsb_addr;
          op <= lsb_op;
          wdata <= lsb_wdata;
        end else if (accept_ok && if_req) begin
          state <= MC_FETCH;
          addr <= if_addr;
          op <= F3_LW;
        end
      end else if (st) begin
        if (rob_clear) sup <= 1'b1;
        if (!io_hold) begin
          cnt <= cnt + 3'd1;
          if (cnt == n - 3'd1) begin
            state <= MC_IDLE;
            ld_done <= !(sup || rob_clear);
            lsb_rdata <= 32'd0;
          end
        end
      end else if (rob_clear) begin
        state <= MC_IDLE;
      end else begin
        cnt <= cnt + 3'd1;
        if (cnt != 3'd0) buf_q <= buf_n;
        if (cnt == n) begin
          state <= MC_IDLE;
          if (state == MC_LOAD) begin
            ld_done <= 1'b1;
            lsb_rdata <= ext_load(op, buf_n);
          end else begin
            f_done <= 1'b1;
            if_instr <= buf_n;
          end
        end
      end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed cycle-exact checks of mem_ctrl against a byte-addressed RAM model
module tb_mem_ctrl;
  logic clk = 0, rst = 1, rdy = 1, rob_clear = 0;
  logic lsb_req = 0, lsb_is_store = 0, if_req = 0, io_buffer_full = 0;
  logic [2:0] lsb_op = 0;
  logic [31:0] lsb_addr = 0, lsb_wdata = 0, if_addr = 0;
  logic lsb_welcome, lsb_done, if_done, mem_wr;
  logic [31:0] lsb_rdata, if_instr, mem_a;
  logic [7:0] mem_din, mem_dout, io_last;
  logic [7:0] ram [0:4095];
  int io_cnt;
  int nchk = 0, nerr = 0;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rob_clear(rob_clear),
    .lsb_req(lsb_req), .lsb_is_store(lsb_is_store), .lsb_op(lsb_op), .lsb_addr(lsb_addr),
    .lsb_wdata(lsb_wdata), .lsb_welcome(lsb_welcome), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_instr(if_instr),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  // RAM returns the byte for the address seen at the previous edge; IO writes are logged, not stored
  always @(posedge clk)
    if (rst) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 8'h5A;
      ram[12'h100] <= 8'h11; ram[12'h101] <= 8'h22; ram[12'h102] <= 8'h33; ram[12'h103] <= 8'h44;
      ram[12'h200] <= 8'h80; ram[12'h210] <= 8'h34; ram[12'h211] <= 8'hF2;
      ram[12'h400] <= 8'h93; ram[12'h401] <= 8'h00; ram[12'h402] <= 8'h10; ram[12'h403] <= 8'h00;
      mem_din <= 8'h00;
      io_cnt <= 0;
      io_last <= 8'h00;
    end else begin
      mem_din <= ram[mem_a[11:0]];
      if (mem_wr) begin
        if (mem_a >= 32'h0003_0000) begin
          io_cnt <= io_cnt + 1;
          io_last <= mem_dout;
        end else ram[mem_a[11:0]] <= mem_dout;
      end
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic st, input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
    lsb_req = 1; lsb_is_store = st; lsb_op = op; lsb_addr = a; lsb_wdata = wd;
  endtask

  // a load issued this cycle: expects done exactly n+2 cycles later with the given data
  task automatic load_chk(input string tag, input logic [2:0] op, input logic [31:0] a, input int n, input logic [31:0] exp);
    req(0, op, a, 0);
    #1 check({tag, "_welcome"}, {31'd0, lsb_welcome}, 1);
    tick();
    lsb_req = 0;
    check({tag, "_a0"}, mem_a, a);
    repeat (n) tick();
    check({tag, "_early"}, {31'd0, lsb_done}, 0);
    tick();
    check({tag, "_done"}, {31'd0, lsb_done}, 1);
    check({tag, "_data"}, lsb_rdata, exp);
    tick();
  endtask

  initial begin
    tick(); tick();
    rst = 0;
    #1;
    check("rst_welcome", {31'd0, lsb_welcome}, 1);
    check("rst_wr", {31'd0, mem_wr}, 0);
    check("rst_a", mem_a, 0);
    check("rst_done", {30'd0, lsb_done, if_done}, 0);
    check("rst_rdata", lsb_rdata, 0);
    tick();

    // LW with exact address sequence
    req(0, 3'b010, 32'h100, 0);
    tick();
    lsb_req = 0;
    #1;
    check("lw_welcome_busy", {31'd0, lsb_welcome}, 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("lw_a%0d", i), mem_a, 32'h100 + i);
      check($sformatf("lw_wr%0d", i), {31'd0, mem_wr}, 0);
      tick();
    end
    check("lw_not_yet", {31'd0, lsb_done}, 0);
    tick();
    check("lw_done", {31'd0, lsb_done}, 1);
    check("lw_data", lsb_rdata, 32'h44332211);
    check("lw_welcome_done", {31'd0, lsb_welcome}, 0);
    tick();
    check("lw_pulse", {31'd0, lsb_done}, 0);
    check("lw_welcome_back", {31'd0, lsb_welcome}, 1);

    load_chk("lb", 3'b000, 32'h200, 1, 32'hFFFFFF80);
    load_chk("lbu", 3'b100, 32'h200, 1, 32'h00000080);
    load_chk("lh", 3'b001, 32'h210, 2, 32'hFFFFF234);
    load_chk("lhu", 3'b101, 32'h210, 2, 32'h0000F234);

    // SH writes two bytes only
    req(1, 3'b001, 32'h300, 32'hDEADBEEF);
    tick();
    lsb_req = 0;
    #1;
    check("sh_wr0", {23'd0, mem_wr, mem_dout}, 32'h1EF);
    check("sh_a0", mem_a, 32'h300);
    tick();
    check("sh_wr1", {23'd0, mem_wr, mem_dout}, 32'h1BE);
    check("sh_a1", mem_a, 32'h301);
    tick();
    check("sh_done", {30'd0, lsb_done, mem_wr}, 32'h2);
    check("sh_rdata", lsb_rdata, 0);
    check("sh_ram", {8'd0, ram[12'h302], ram[12'h301], ram[12'h300]}, 32'h5ABEEF);
    tick();

    // IO store throttled for three cycles
    req(1, 3'b000, 32'h0003_0000, 32'h00000077);
    tick();
    lsb_req = 0;
    io_buffer_full = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("io_hold%0d", i), {31'd0, mem_wr}, 0);
      check($sformatf("io_a%0d", i), mem_a, 32'h0003_0000);
      tick();
    end
    io_buffer_full = 0;
    #1;
    check("io_wr", {23'd0, mem_wr, mem_dout}, 32'h177);
    check("io_early", {31'd0, lsb_done}, 0);
    tick();
    check("io_done", {30'd0, lsb_done, mem_wr}, 32'h2);
    check("io_count", io_cnt, 1);
    check("io_byte", {24'd0, io_last}, 32'h77);
    tick();

    // LSB wins over fetch; fetch follows the done cycle
    req(0, 3'b010, 32'h100, 0);
    if_req = 1; if_addr = 32'h400;
    tick();
    lsb_req = 0;
    check("pri_a", mem_a, 32'h100);
    repeat (5) tick();
    check("pri_ldone", {31'd0, lsb_done}, 1);
    check("pri_ldata", lsb_rdata, 32'h44332211);
    check("pri_ifidle", {31'd0, if_done}, 0);
    tick(); tick();
    check("pri_fa", mem_a, 32'h400);
    repeat (4) tick();
    check("pri_if_early", {31'd0, if_done}, 0);
    tick();
    check("pri_ifdone", {31'd0, if_done}, 1);
    check("pri_instr", if_instr, 32'h00100093);
    if_req = 0;
    tick();
    check("pri_ifpulse", {31'd0, if_done}, 0);

    // rob_clear aborts a load
    req(0, 3'b010, 32'h100, 0);
    tick();
    lsb_req = 0;
    tick();
    rob_clear = 1;
    tick();
    rob_clear = 0;
    #1;
    check("abt_idle", {31'd0, lsb_welcome}, 1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("abt_nodone%0d", i), {31'd0, lsb_done}, 0);
      check($sformatf("abt_ahold%0d", i), mem_a, 32'h101);
      tick();
    end

    // rob_clear mid store: all bytes written, done suppressed
    req(1, 3'b010, 32'h500, 32'hCAFEF00D);
    tick();
    lsb_req = 0;
    for (int i = 0; i < 4; i++) begin
      rob_clear = (i == 1);
      #1;
      check($sformatf("swc_wr%0d", i), {31'd0, mem_wr}, 1);
      if (i == 1) check("swc_welcome", {31'd0, lsb_welcome}, 0);
      tick();
    end
    rob_clear = 0;
    check("swc_nodone", {31'd0, lsb_done}, 0);
    check("swc_ram", {ram[12'h503], ram[12'h502], ram[12'h501], ram[12'h500]}, 32'hCAFEF00D);
    tick();

    // rdy low freezes the store
    req(1, 3'b000, 32'h310, 32'h42);
    tick();
    lsb_req = 0;
    rdy = 0;
    #1 check("rdy_wr0", {31'd0, mem_wr}, 0);
    tick();
    check("rdy_wr1", {31'd0, mem_wr}, 0);
    tick();
    rdy = 1;
    #1;
    check("rdy_wr", {23'd0, mem_wr, mem_dout}, 32'h142);
    check("rdy_a", mem_a, 32'h310);
    tick();
    check("rdy_done", {31'd0, lsb_done}, 1);
    check("rdy_ram", {24'd0, ram[12'h310]}, 32'h42);
    tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
